// File: rtl/serving_timer_pkg.sv
// Shared definitions for the serving machine timer: register word indices,
// CTRL field positions and the byte-enable merge used by every writable register.
package serving_timer_pkg;

    localparam logic [2:0] REG_MTIME_LO = 3'd0;
    localparam logic [2:0] REG_MTIME_HI = 3'd1;
    localparam logic [2:0] REG_CMP_LO   = 3'd2;
    localparam logic [2:0] REG_CMP_HI   = 3'd3;
    localparam logic [2:0] REG_CTRL     = 3'd4;
    localparam logic [2:0] REG_STATUS   = 3'd5;

    localparam int CTRL_EN        = 0;
    localparam int CTRL_PRESC_LSB = 8;

    function automatic logic [31:0] merge_bytes(input logic [31:0] cur,
                                                input logic [31:0] dat,
                                                input logic [3:0]  sel);
        logic [31:0] res;
        for (int b = 0; b < 4; b++) begin
            res[8*b +: 8] = sel[b] ? dat[8*b +: 8] : cur[8*b +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/serving_timer_presc.sv
// Timer prescaler: a down-counter reloaded with the divider value, ticking on
// terminal count 0, so one tick is produced every PRESC+1 enabled cycles.
module serving_timer_presc #(
    parameter int PRESC_W = 8
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_en,
    input  logic               i_clr,
    input  logic [PRESC_W-1:0] i_presc,
    output logic               o_tick
);

    logic [PRESC_W-1:0] cnt_q, cnt_d;

    assign o_tick = i_en && (cnt_q == '0);

    // i_presc is the divider that holds after this edge, so a CTRL write reloads the new value
    always_comb begin
        cnt_d = cnt_q;
        if (i_clr) begin
            cnt_d = i_presc;
        end else if (!i_en) begin
            cnt_d = '0;
        end else if (o_tick) begin
            cnt_d = i_presc;
        end else begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/serving_timer.sv
// 64-bit RISC-V machine timer on the serving external Wishbone port: mtime,
// mtimecmp, a read shadow for tear-free 64-bit reads, and a level timer irq.
module serving_timer
    import serving_timer_pkg::*;
#(
    parameter int          PRESC_W   = 8,
    parameter logic [63:0] CMP_RESET = 64'hFFFF_FFFF_FFFF_FFFF
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [31:0] i_wb_adr,
    input  logic [31:0] i_wb_dat,
    input  logic [3:0]  i_wb_sel,
    input  logic        i_wb_we,
    input  logic        i_wb_stb,
    output logic [31:0] o_wb_rdt,
    output logic        o_wb_ack,
    output logic        o_timer_irq
);

    logic               ack_q, ack_d;
    logic [31:0]        rdt_q, rdt_d;
    logic               irq_q, irq_d;
    logic [63:0]        mtime_q, mtime_d;
    logic [63:0]        cmp_q, cmp_d;
    logic [31:0]        shadow_q, shadow_d;
    logic               en_q, en_d;
    logic [PRESC_W-1:0] presc_q, presc_d;
    logic               tick, presc_clr;
    logic [2:0]         idx;
    logic               req, wr, rd;
    logic [31:0]        ctrl_rd, ctrl_wr, hi_wr;
    logic               unused_bits;

    assign idx         = i_wb_adr[4:2];
    assign req         = i_wb_stb & ~ack_q;
    assign wr          = req & i_wb_we;
    assign rd          = req & ~i_wb_we;
    assign unused_bits = ^{i_wb_adr[31:5], i_wb_adr[1:0], ctrl_wr};

    always_comb begin
        ctrl_rd                             = '0;
        ctrl_rd[CTRL_EN]                    = en_q;
        ctrl_rd[CTRL_PRESC_LSB +: PRESC_W]  = presc_q;
    end

    assign ctrl_wr = merge_bytes(ctrl_rd, i_wb_dat, i_wb_sel);
    assign hi_wr   = merge_bytes(mtime_q[63:32], i_wb_dat, i_wb_sel);

    serving_timer_presc #(.PRESC_W(PRESC_W)) u_presc (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_en    (en_q),
        .i_clr   (presc_clr),
        .i_presc (presc_d),
        .o_tick  (tick)
    );

    always_comb begin
        ack_d     = i_wb_stb & ~ack_q;
        rdt_d     = '0;
        irq_d     = (mtime_q >= cmp_q);
        mtime_d   = mtime_q + 64'(tick);
        cmp_d     = cmp_q;
        shadow_d  = shadow_q;
        en_d      = en_q;
        presc_d   = presc_q;
        presc_clr = 1'b0;

        // a bus write to either mtime half replaces this cycle's increment entirely
        if (wr) begin
            case (idx)
                REG_MTIME_LO: mtime_d = {mtime_q[63:32], merge_bytes(mtime_q[31:0], i_wb_dat, i_wb_sel)};
                REG_MTIME_HI: begin
                    mtime_d  = {hi_wr, mtime_q[31:0]};
                    shadow_d = hi_wr;
                end
                REG_CMP_LO:   cmp_d[31:0]  = merge_bytes(cmp_q[31:0], i_wb_dat, i_wb_sel);
                REG_CMP_HI:   cmp_d[63:32] = merge_bytes(cmp_q[63:32], i_wb_dat, i_wb_sel);
                REG_CTRL: begin
                    en_d      = ctrl_wr[CTRL_EN];
                    presc_d   = ctrl_wr[CTRL_PRESC_LSB +: PRESC_W];
                    presc_clr = 1'b1;
                end
                default: ;
            endcase
        end

        if (rd) begin
            case (idx)
                REG_MTIME_LO: begin
                    rdt_d    = mtime_q[31:0];
                    shadow_d = mtime_q[63:32];
                end
                REG_MTIME_HI: rdt_d = shadow_q;
                REG_CMP_LO:   rdt_d = cmp_q[31:0];
                REG_CMP_HI:   rdt_d = cmp_q[63:32];
                REG_CTRL:     rdt_d = ctrl_rd;
                REG_STATUS:   rdt_d = {31'h0, irq_q};
                default:      rdt_d = '0;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            ack_q    <= 1'b0;
            rdt_q    <= '0;
            irq_q    <= 1'b0;
            mtime_q  <= '0;
            cmp_q    <= CMP_RESET;
            shadow_q <= '0;
            en_q     <= 1'b1;
            presc_q  <= '0;
        end else begin
            ack_q    <= ack_d;
            rdt_q    <= rdt_d;
            irq_q    <= irq_d;
            mtime_q  <= mtime_d;
            cmp_q    <= cmp_d;
            shadow_q <= shadow_d;
            en_q     <= en_d;
            presc_q  <= presc_d;
        end
    end

    assign o_wb_ack    = ack_q;
    assign o_wb_rdt    = rdt_q;
    assign o_timer_irq = irq_q;

endmodule

// File: tb/tb_serving_timer.sv
// Bench for serving_timer: randomized bus traffic checked against a model that
// derives mtime from edge numbers (ticks = multiples of PRESC+1 since the last CTRL write).
module tb_serving_timer;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] adr   = '0;
    logic [31:0] dat   = '0;
    logic [3:0]  sel   = '0;
    logic        we    = 1'b0;
    logic        stb   = 1'b0;
    logic [31:0] rdt;
    logic        ack, irq;

    int cyc     = 0;
    int n_pass  = 0;
    int n_total = 0;

    logic [63:0] m_base, m_cmp;
    int          m_base_edge, m_c0, m_p;
    logic        m_en;
    logic [31:0] m_shadow;

    serving_timer dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_wb_adr    (adr),
        .i_wb_dat    (dat),
        .i_wb_sel    (sel),
        .i_wb_we     (we),
        .i_wb_stb    (stb),
        .o_wb_rdt    (rdt),
        .o_wb_ack    (ack),
        .o_timer_irq (irq)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] merge32(input logic [31:0] cur, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] mask = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
        return (cur & ~mask) | (d & mask);
    endfunction

    // mtime value held after edge e
    function automatic logic [63:0] mt_at(input int e);
        int n = 0;
        if (m_en) n = (e - m_c0) / (m_p + 1) - (m_base_edge - m_c0) / (m_p + 1);
        return m_base + 64'(n);
    endfunction

    function automatic logic irq_after(input int e);
        return mt_at(e - 1) >= m_cmp;
    endfunction

    function automatic logic [31:0] ctrl_val();
        return {16'h0, 8'(m_p), 7'h0, m_en};
    endfunction

    task automatic model_reset();
        m_base      = '0;
        m_base_edge = cyc;
        m_c0        = cyc;
        m_p         = 0;
        m_en        = 1'b1;
        m_cmp       = '1;
        m_shadow    = '0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic xfer(input logic w, input logic [2:0] i, input logic [31:0] d, input logic [3:0] s,
                        output logic [31:0] r, output int e);
        adr = $urandom;
        adr[4:2] = i;
        dat = d; sel = s; we = w; stb = 1'b1;
        e = -1; r = '0;
        for (int k = 0; k < 4 && e < 0; k++) begin
            @(posedge clk); #1;
            if (ack === 1'b1) begin e = cyc; r = rdt; end
        end
        stb = 1'b0; we = 1'b0;
        if (e < 0) begin
            n_total++;
            $display("FAIL ack_timeout idx=%0d got no ack in 4 cycles, required ack", i);
            e = cyc;
        end
        @(posedge clk); #1;
    endtask

    task automatic wb_write(input logic [2:0] i, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] r, cw;
        logic [63:0] pre;
        int e;
        xfer(1'b1, i, d, s, r, e);
        pre = mt_at(e - 1);
        case (i)
            3'd0: begin m_base = {pre[63:32], merge32(pre[31:0], d, s)}; m_base_edge = e; end
            3'd1: begin m_shadow = merge32(pre[63:32], d, s); m_base = {m_shadow, pre[31:0]}; m_base_edge = e; end
            3'd2: m_cmp[31:0]  = merge32(m_cmp[31:0], d, s);
            3'd3: m_cmp[63:32] = merge32(m_cmp[63:32], d, s);
            3'd4: begin
                m_base = mt_at(e); m_base_edge = e; m_c0 = e;
                cw = merge32(ctrl_val(), d, s);
                m_en = cw[0]; m_p = int'(cw[15:8]);
            end
            default: ;
        endcase
    endtask

    task automatic wb_read(input logic [2:0] i, output logic [31:0] r, output logic [31:0] exp, output int e);
        logic [63:0] v;
        xfer(1'b0, i, $urandom, 4'($urandom), r, e);
        case (i)
            3'd0: begin v = mt_at(e - 1); exp = v[31:0]; m_shadow = v[63:32]; end
            3'd1: exp = m_shadow;
            3'd2: exp = m_cmp[31:0];
            3'd3: exp = m_cmp[63:32];
            3'd4: exp = ctrl_val();
            3'd5: exp = {31'h0, irq_after(e - 1)};
            default: exp = '0;
        endcase
    endtask

    task automatic test_reset();
        logic [31:0] r, exp;
        int e;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_total++; if (ack !== 1'b0) $display("FAIL rst_ack got=%b exp=0", ack); else n_pass++;
        n_total++; if (rdt !== 32'h0) $display("FAIL rst_rdt got=%h exp=0", rdt); else n_pass++;
        n_total++; if (irq !== 1'b0) $display("FAIL rst_irq got=%b exp=0", irq); else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        @(posedge clk); #1;
        idle($urandom_range(5, 30));
        wb_read(3'd0, r, exp, e);
        n_total++; if (r !== exp) $display("FAIL idle_mtime_lo got=%h exp=%h", r, exp); else n_pass++;
        wb_read(3'd4, r, exp, e);
        n_total++; if (r !== exp) $display("FAIL rst_ctrl got=%h exp=%h", r, exp); else n_pass++;
        wb_read(3'd3, r, exp, e);
        n_total++; if (r !== exp) $display("FAIL rst_cmp_hi got=%h exp=%h", r, exp); else n_pass++;
        n_total++; if (irq !== irq_after(cyc)) $display("FAIL idle_irq got=%b exp=%b", irq, irq_after(cyc)); else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [63:0] v;
        adr = 32'h0; we = 1'b0; sel = 4'hF; stb = 1'b1;
        @(posedge clk); #1;
        v = mt_at(cyc - 1); m_shadow = v[63:32];
        n_total++; if (ack !== 1'b1) $display("FAIL ack_latency got=%b exp=1", ack); else n_pass++;
        n_total++; if (rdt !== v[31:0]) $display("FAIL b2b_rdt0 got=%h exp=%h", rdt, v[31:0]); else n_pass++;
        @(posedge clk); #1;
        n_total++; if (ack !== 1'b0) $display("FAIL ack_gap got=%b exp=0", ack); else n_pass++;
        n_total++; if (rdt !== 32'h0) $display("FAIL rdt_idle got=%h exp=0", rdt); else n_pass++;
        @(posedge clk); #1;
        v = mt_at(cyc - 1); m_shadow = v[63:32];
        n_total++; if (ack !== 1'b1) $display("FAIL ack_second got=%b exp=1", ack); else n_pass++;
        n_total++; if (rdt !== v[31:0]) $display("FAIL b2b_rdt1 got=%h exp=%h", rdt, v[31:0]); else n_pass++;
        stb = 1'b0;
        @(posedge clk); #1;
        n_total++; if (ack !== 1'b0) $display("FAIL ack_single got=%b exp=0", ack); else n_pass++;
    endtask

    task automatic test_presc();
        logic [31:0] r0, r1, exp;
        int e0, e1, d, q, p;
        logic en;
        wb_write(3'd4, 32'h0000_0301, 4'hF);
        wb_read(3'd0, r0, exp, e0);
        n_total++; if (r0 !== exp) $display("FAIL presc3_lo0 got=%h exp=%h", r0, exp); else n_pass++;
        idle(40);
        wb_read(3'd0, r1, exp, e1);
        n_total++; if (r1 !== exp) $display("FAIL presc3_lo1 got=%h exp=%h", r1, exp); else n_pass++;
        d = int'(r1 - r0);
        q = (e1 - e0) / 4;
        n_total++; if (d < q - 1 || d > q + 1) $display("FAIL presc3_rate got=%0d exp=%0d+-1", d, q); else n_pass++;
        for (int k = 0; k < 6; k++) begin
            p  = $urandom_range(0, 6);
            en = (k == 5) ? 1'b0 : ($urandom_range(0, 3) != 0);
            wb_write(3'd4, {16'h0, 8'(p), 7'h0, en}, 4'hF);
            idle($urandom_range(5, 40));
            wb_read(3'd0, r1, exp, e1);
            n_total++; if (r1 !== exp) $display("FAIL presc_rand p=%0d en=%b got=%h exp=%h", p, en, r1, exp); else n_pass++;
        end
    endtask

    task automatic test_wrap();
        logic [31:0] r, exp, hv;
        logic [3:0]  hs;
        int e;
        wb_write(3'd4, 32'h0000_0001, 4'hF);
        wb_write(3'd1, 32'h0, 4'hF);
        wb_write(3'd0, 32'hFFFF_FFFE, 4'hF);
        idle(3);
        wb_read(3'd0, r, exp, e);
        n_total++; if (r !== exp || r > 32'd16) $display("FAIL wrap_lo got=%h exp=%h", r, exp); else n_pass++;
        wb_read(3'd1, r, exp, e);
        n_total++; if (r !== exp) $display("FAIL wrap_hi_shadow got=%h exp=%h", r, exp); else n_pass++;
        wb_write(3'd0, $urandom, 4'hF);
        idle($urandom_range(1, 8));
        wb_read(3'd1, r, exp, e);
        n_total++; if (r !== exp) $display("FAIL shadow_held got=%h exp=%h", r, exp); else n_pass++;
        hv = $urandom; hs = 4'($urandom);
        wb_write(3'd1, hv, hs);
        wb_read(3'd1, r, exp, e);
        n_total++; if (r !== exp) $display("FAIL shadow_hi_wr got=%h exp=%h", r, exp); else n_pass++;
    endtask

    task automatic test_irq();
        logic [63:0] v;
        wb_write(3'd1, 32'h0, 4'hF);
        wb_write(3'd3, 32'h0, 4'hF);
        wb_write(3'd2, 32'h10, 4'hF);
        wb_write(3'd0, 32'h0, 4'hF);
        for (int k = 0; k < 30; k++) begin
            @(posedge clk); #1;
            n_total++; if (irq !== irq_after(cyc)) $display("FAIL irq_rise t=%0d got=%b exp=%b", k, irq, irq_after(cyc)); else n_pass++;
        end
        n_total++; if (irq !== 1'b1) $display("FAIL irq_high got=%b exp=1", irq); else n_pass++;
        wb_write(3'd3, 32'h1, 4'hF);
        @(posedge clk); #1;
        n_total++; if (irq !== 1'b0) $display("FAIL irq_drop got=%b exp=0", irq); else n_pass++;
        for (int it = 0; it < 5; it++) begin
            wb_write(3'd3, 32'h0, 4'hF);
            v = mt_at(cyc);
            wb_write(3'd2, v[31:0] + $urandom_range(4, 30), 4'hF);
            for (int k = 0; k < 25; k++) begin
                @(posedge clk); #1;
                n_total++; if (irq !== irq_after(cyc)) $display("FAIL irq_rand it=%0d t=%0d got=%b exp=%b", it, k, irq, irq_after(cyc)); else n_pass++;
            end
        end
    endtask

    task automatic test_regs();
        logic [31:0] r, exp;
        int e;
        wb_write(3'd2, 32'hFFFF_FFFF, 4'hF);
        wb_write(3'd2, 32'h0000_AB00, 4'b0010);
        wb_read(3'd2, r, exp, e);
        n_total++; if (r !== exp || r !== 32'hFFFF_ABFF) $display("FAIL cmp_byte got=%h exp=%h", r, exp); else n_pass++;
        for (int k = 0; k < 4; k++) begin
            wb_write(3'd3, $urandom, 4'($urandom));
            wb_read(3'd3, r, exp, e);
            n_total++; if (r !== exp) $display("FAIL cmp_hi_rand got=%h exp=%h", r, exp); else n_pass++;
        end
        wb_read(3'd5, r, exp, e);
        n_total++; if (r !== exp) $display("FAIL status0 got=%h exp=%h", r, exp); else n_pass++;
        wb_write(3'd5, $urandom, 4'hF);
        wb_read(3'd5, r, exp, e);
        n_total++; if (r !== exp) $display("FAIL status_ro got=%h exp=%h", r, exp); else n_pass++;
        wb_write(3'd6, $urandom, 4'hF);
        wb_read(3'd6, r, exp, e);
        n_total++; if (r !== exp) $display("FAIL idx6 got=%h exp=%h", r, exp); else n_pass++;
        wb_read(3'd7, r, exp, e);
        n_total++; if (r !== exp) $display("FAIL idx7 got=%h exp=%h", r, exp); else n_pass++;
        wb_write(3'd4, 32'hFFFF_FFFF, 4'hF);
        wb_read(3'd4, r, exp, e);
        n_total++; if (r !== exp) $display("FAIL ctrl_mask got=%h exp=%h", r, exp); else n_pass++;
        wb_write(3'd4, 32'h0000_0001, 4'hF);
    endtask

    task automatic test_reset_mid();
        logic [31:0] r, exp;
        logic [63:0] v;
        int e;
        adr = 32'h0; we = 1'b0; sel = 4'hF; stb = 1'b1;
        #3;
        rst_n = 1'b0;
        #1;
        n_total++; if ({ack, rdt, irq} !== 34'h0) $display("FAIL midrst_async got=%b/%h/%b exp=0", ack, rdt, irq); else n_pass++;
        @(posedge clk); #1;
        n_total++; if (ack !== 1'b0) $display("FAIL midrst_noack got=%b exp=0", ack); else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        @(posedge clk); #1;
        v = mt_at(cyc - 1); m_shadow = v[63:32];
        n_total++; if (ack !== 1'b1) $display("FAIL midrst_newreq got=%b exp=1", ack); else n_pass++;
        n_total++; if (rdt !== v[31:0]) $display("FAIL midrst_rdt got=%h exp=%h", rdt, v[31:0]); else n_pass++;
        stb = 1'b0;
        @(posedge clk); #1;
        wb_read(3'd4, r, exp, e);
        n_total++; if (r !== exp) $display("FAIL midrst_ctrl got=%h exp=%h", r, exp); else n_pass++;
        wb_read(3'd2, r, exp, e);
        n_total++; if (r !== exp) $display("FAIL midrst_cmp got=%h exp=%h", r, exp); else n_pass++;
        n_total++; if (irq !== irq_after(cyc)) $display("FAIL midrst_irq got=%b exp=%b", irq, irq_after(cyc)); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_presc();
        test_wrap();
        test_irq();
        test_regs();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #500_000;
        $display("FAIL watchdog got=timeout exp=finish (%0d/%0d so far)", n_pass, n_total);
        $fatal(1);
    end

endmodule
